// File: rtl/seq_priority_encoder_pkg.sv
// rtl/seq_priority_encoder_pkg.sv - shared types and width helpers for the sequential priority encoder
package seq_enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int idx_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

   // Request width must be a power of two so every index value maps to a bit.
   function automatic bit width_ok(input int width);
      return (width >= 2) && ((width & (width - 1)) == 0);
   endfunction

   localparam bit DEFAULT_WIDTH_OK = width_ok(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_priority_encoder_if.sv
// rtl/seq_priority_encoder_if.sv - request/index handshake bundle for the sequential priority encoder
interface seq_priority_encoder_if
   import seq_enc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   localparam int IDX_W = idx_w(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] req;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             zero_err;

   modport master (
      output in_valid, req, out_ready,
      input  in_ready, out_valid, out_idx, out_last, zero_err
   );

   modport slave (
      input  in_valid, req, out_ready,
      output in_ready, out_valid, out_idx, out_last, zero_err
   );

endinterface

// File: rtl/seq_priority_encoder_lsb_find.sv
// rtl/seq_priority_encoder_lsb_find.sv - combinational lowest-set-bit finder with one-hot detect
module lsb_find
   import seq_enc_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int IDX_W = idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             found,
   output logic             single
);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = i[IDX_W-1:0];
            found = 1'b1;
         end
      end
   end

   assign single = found && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/seq_priority_encoder.sv
// rtl/seq_priority_encoder.sv - captures a multi-hot vector and emits its set-bit indices lowest first
module seq_priority_encoder
   import seq_enc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic                    clk,
   input logic                    rst,
   seq_priority_encoder_if.slave  bus
);
   localparam int IDX_W = idx_w(WIDTH);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("seq_priority_encoder: WIDTH must be a power of two >= 2");
   end

   state_t           state;
   logic [WIDTH-1:0] pending;
   logic             zero_err;
   logic [IDX_W-1:0] low_idx;
   logic             found;
   logic             single;

   lsb_find #(.WIDTH(WIDTH)) u_lsb_find (
      .vec    (pending),
      .idx    (low_idx),
      .found  (found),
      .single (single)
   );

   // Every output is decoded from state/pending/zero_err only.
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == EMIT) && found;
   assign bus.out_idx   = low_idx;
   assign bus.out_last  = (state == EMIT) && single;
   assign bus.zero_err  = zero_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pending  <= '0;
         zero_err <= 1'b0;
      end else begin
         zero_err <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  pending <= bus.req;
                  if (bus.req == '0) begin
                     zero_err <= 1'b1;
                  end else begin
                     state <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (bus.out_ready) begin
                  pending <= pending & ~(WIDTH'(1) << low_idx);
                  if (single) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// tb/tb_seq_priority_encoder.sv - randomized self-checking bench against a queue-based index model
module tb_seq_priority_encoder;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   seq_priority_encoder_if #(.WIDTH(W)) bus ();

   seq_priority_encoder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // mode: 0 ready always, 1 random ready, 2 toggling 1,0,1.., 3 stalled for first 3 cycles
   // poke: pulse in_valid with a foreign vector throughout emission
   task automatic run_vector(input logic [W-1:0] v, input int mode, input bit poke);
      int q[$];
      int c;
      int hs;
      bit rdy;
      check("idle_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.req      = v;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (v == '0) begin
         check("zero_err_pulse", 32'(bus.zero_err), 32'd1);
         check("zero_no_valid", 32'(bus.out_valid), 32'd0);
         check("zero_ready", 32'(bus.in_ready), 32'd1);
         return;
      end
      for (int i = 0; i < W; i++) if (v[i]) q.push_back(i);
      c  = 0;
      hs = 0;
      while (q.size() != 0) begin
         if (c > 100) begin
            check("emit_timeout", 32'(c), 32'd0);
            return;
         end
         check("emit_valid", 32'(bus.out_valid), 32'd1);
         check("emit_busy", 32'(bus.in_ready), 32'd0);
         check("emit_idx", 32'(bus.out_idx), 32'(q[0]));
         check("emit_last", 32'(bus.out_last), 32'(q.size() == 1));
         check("emit_no_zero_err", 32'(bus.zero_err), 32'd0);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            2:       rdy = (c % 2 == 0);
            default: rdy = (c >= 3);
         endcase
         bus.out_ready = rdy;
         bus.in_valid  = poke;
         bus.req       = poke ? 8'h08 : v;
         @(negedge clk);
         if (rdy) begin
            void'(q.pop_front());
            hs++;
         end
         c++;
      end
      bus.in_valid = 1'b0;
      check("handshakes", 32'(hs), 32'($countones(v)));
      check("back_to_idle", 32'(bus.in_ready), 32'd1);
      check("idle_no_valid", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.req       = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_idx", 32'(bus.out_idx), 32'd0);
      check("rst_out_last", 32'(bus.out_last), 32'd0);
      check("rst_zero_err", 32'(bus.zero_err), 32'd0);
      rst = 1'b0;

      run_vector(8'b0010_0110, 0, 1'b0);
      run_vector(8'h81, 3, 1'b0);
      run_vector(8'h00, 0, 1'b0);
      run_vector(8'h04, 0, 1'b0);
      run_vector(8'hFF, 2, 1'b0);
      run_vector(8'h80, 0, 1'b0);
      run_vector(8'h61, 0, 1'b1);

      // Reset between edges while emitting 8'hF0, after index 4 has been taken.
      bus.in_valid = 1'b1;
      bus.req      = 8'hF0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("mid_first_idx", 32'(bus.out_idx), 32'd4);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      check("mid_rst_pending", 32'(dut.pending), 32'd0);
      bus.in_valid = 1'b1;
      bus.req      = 8'h02;
      @(negedge clk);
      check("no_capture_in_rst", 32'(dut.pending), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("post_rst_valid", 32'(bus.out_valid), 32'd1);
      check("post_rst_idx", 32'(bus.out_idx), 32'd1);
      check("post_rst_last", 32'(bus.out_last), 32'd1);
      @(negedge clk);
      check("post_rst_idle", 32'(bus.in_ready), 32'd1);

      for (int n = 0; n < 40; n++) begin
         run_vector(W'($urandom_range(0, 255)), 1, (n % 5 == 0));
      end
      run_vector(8'h00, 0, 1'b0);
      run_vector(8'h00, 0, 1'b0);
      run_vector(8'h01, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule
